// File: rtl/iram_loader_pkg.sv
// Shared types and constants for the IRAM loader.
// Frame: header, 4-byte LE base, 4-byte LE word count, LE data words.
package iram_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        LEN,
        DATA
    } loader_state_t;

    localparam logic [7:0] LOAD_HDR = 8'h5A;

endpackage

// File: rtl/iram_loader_gap_timer.sv
// Inter-byte idle watchdog for the IRAM loader.
// Expires once GAP_CYCLES byte-less cycles have elapsed inside a frame.
module gap_timer
    import iram_loader_pkg::*;
#(
    parameter int GAP_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam int CW = $clog2(GAP_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(GAP_CYCLES);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || clr_i) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Not gated by clr_i: a byte landing on the expiry cycle still aborts.
    assign expire_o = en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/iram_loader.sv
// Host byte stream to IRAM word writer; holds the core in reset
// while a program image is being loaded.
module iram_loader
    import iram_loader_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int GAP_CYCLES = 1000000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            byte_valid_i,
    input  logic [7:0]      byte_data_i,
    output logic            iram_wr_en_o,
    output logic [XLEN-1:0] iram_wr_addr_o,
    output logic [XLEN-1:0] iram_wr_data_o,
    output logic            cpu_rst_o,
    output logic            done_o,
    output logic            err_o
);

    loader_state_t   state_q, state_d;
    logic [1:0]      bcnt_q, bcnt_d;
    logic [XLEN-1:0] base_q, base_d;
    logic [XLEN-1:0] n_q, n_d;
    logic [XLEN-1:0] idx_q, idx_d;
    logic [XLEN-1:0] shift_q, shift_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            wr_en_q, wr_en_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            cpu_rst_q;
    logic            expire;

    gap_timer #(
        .GAP_CYCLES(GAP_CYCLES)
    ) u_gap (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (state_q != IDLE),
        .clr_i   (byte_valid_i),
        .expire_o(expire)
    );

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        base_d  = base_q;
        n_d     = n_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_en_d = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (expire) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end else if (byte_valid_i) begin
            unique case (state_q)
                IDLE: begin
                    if (byte_data_i == LOAD_HDR) begin
                        state_d = ADDR;
                        bcnt_d  = '0;
                    end
                end
                ADDR: begin
                    base_d = {byte_data_i, base_q[XLEN-1:8]};
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        state_d = LEN;
                    end
                end
                LEN: begin
                    n_d    = {byte_data_i, n_q[XLEN-1:8]};
                    bcnt_d = bcnt_q + 2'd1;
                    idx_d  = '0;
                    if (bcnt_q == 2'd3) begin
                        if (base_q[1:0] != 2'b00) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end else if (n_d == '0) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
                DATA: begin
                    shift_d = {byte_data_i, shift_q[XLEN-1:8]};
                    bcnt_d  = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        wr_en_d = 1'b1;
                        addr_d  = base_q + {idx_q[XLEN-3:0], 2'b00};
                        data_d  = shift_d;
                        idx_d   = idx_q + 1'b1;
                        if (idx_d == n_q) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            bcnt_q    <= '0;
            base_q    <= '0;
            n_q       <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cpu_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcnt_q    <= bcnt_d;
            base_q    <= base_d;
            n_q       <= n_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wr_en_q   <= wr_en_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cpu_rst_q <= (state_d != IDLE);
        end
    end

    assign iram_wr_en_o   = wr_en_q;
    assign iram_wr_addr_o = addr_q;
    assign iram_wr_data_o = data_q;
    assign cpu_rst_o      = cpu_rst_q;
    assign done_o         = done_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_iram_loader.sv
// Self-checking bench for iram_loader: frames are built from their
// parameters, expected writes/pulses derived from the byte schedule.
module tb_iram_loader;

    localparam int GAP = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bv  = 1'b0;
    logic [7:0]  bd  = 8'h00;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_rst;
    logic        done;
    logic        err;

    iram_loader #(
        .XLEN(32),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .byte_valid_i  (bv),
        .byte_data_i   (bd),
        .iram_wr_en_o  (wr_en),
        .iram_wr_addr_o(wr_addr),
        .iram_wr_data_o(wr_data),
        .cpu_rst_o     (cpu_rst),
        .done_o        (done),
        .err_o         (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          bi;
    } ew_t;
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          c;
    } ow_t;
    // kind: 0 done, 1 err on byte bi, 2 err by gap after byte bi
    typedef struct {
        int kind;
        int bi;
        int hb;
    } fr_t;

    logic [7:0]  sq[$];
    int          gq[$];
    int          ed[$];
    logic [31:0] fw[$];
    ew_t         ew[$];
    fr_t         fq[$];
    ow_t         ow[$];
    int          od[$];
    int          oe[$];
    int          orise[$];
    int          ofall[$];
    logic        prev_rst = 1'b0;

    int nchk  = 0;
    int nfail = 0;

    always @(negedge clk) begin
        if (wr_en) ow.push_back('{a: wr_addr, d: wr_data, c: cyc});
        if (done) od.push_back(cyc);
        if (err) oe.push_back(cyc);
        if (cpu_rst && !prev_rst) orise.push_back(cyc);
        if (!cpu_rst && prev_rst) ofall.push_back(cyc);
        prev_rst <= cpu_rst;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nchk++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_b(input logic [7:0] b);
        sq.push_back(b);
        gq.push_back(int'($urandom_range(0, 3)));
    endtask

    task automatic push_w(input logic [31:0] w);
        for (int k = 0; k < 4; k++) push_b(w[8*k+:8]);
    endtask

    task automatic add_frame(input logic [31:0] base, input int n,
                             input int stall);
        int hb;
        int cnt;
        logic [31:0] w;
        cnt = 0;
        hb  = sq.size();
        push_b(8'h5A);
        push_w(base);
        push_w(32'(n));
        if (base[1:0] != 2'b00) begin
            fq.push_back('{1, sq.size() - 1, hb});
            return;
        end
        if (n == 0) begin
            fq.push_back('{0, sq.size() - 1, hb});
            return;
        end
        for (int i = 0; i < n; i++) begin
            w = (fw.size() != 0) ? fw.pop_front() : $urandom;
            for (int k = 0; k < 4; k++) begin
                if (cnt == stall) begin
                    gq[gq.size() - 1] = GAP + 5;
                    fq.push_back('{2, sq.size() - 1, hb});
                    return;
                end
                push_b(w[8*k+:8]);
                cnt++;
            end
            ew.push_back('{a: base + 32'(4 * i), d: w, bi: sq.size() - 1});
        end
        fq.push_back('{0, sq.size() - 1, hb});
    endtask

    task automatic run_stream(input bit drain);
        for (int i = 0; i < sq.size(); i++) begin
            bv = 1'b1;
            bd = sq[i];
            ed.push_back(cyc + 1);
            @(negedge clk);
            bv = 1'b0;
            repeat (gq[i]) @(negedge clk);
        end
        if (drain) repeat (GAP + 10) @(negedge clk);
    endtask

    task automatic clear_all();
        sq.delete(); gq.delete(); ed.delete(); fw.delete();
        ew.delete(); fq.delete(); ow.delete(); od.delete();
        oe.delete(); orise.delete(); ofall.delete();
    endtask

    task automatic compare_all(input string tag);
        int di;
        int ei;
        int c;
        int nd;
        int ne;
        di = 0;
        ei = 0;
        nd = 0;
        ne = 0;
        foreach (fq[j]) begin
            if (fq[j].kind == 0) nd++;
            else ne++;
        end
        chk({tag, ":nwr"}, ow.size(), ew.size());
        chk({tag, ":ndone"}, od.size(), nd);
        chk({tag, ":nerr"}, oe.size(), ne);
        chk({tag, ":nrise"}, orise.size(), fq.size());
        chk({tag, ":nfall"}, ofall.size(), fq.size());
        for (int i = 0; i < ew.size() && i < ow.size(); i++) begin
            chk({tag, ":wr_addr"}, ow[i].a, ew[i].a);
            chk({tag, ":wr_data"}, ow[i].d, ew[i].d);
            chk({tag, ":wr_cyc"}, ow[i].c, ed[ew[i].bi]);
        end
        for (int j = 0; j < fq.size(); j++) begin
            if (j < orise.size())
                chk({tag, ":rise"}, orise[j], ed[fq[j].hb]);
            if (fq[j].kind == 0) begin
                if (di < od.size()) begin
                    chk({tag, ":done_cyc"}, od[di], ed[fq[j].bi]);
                    if (j < ofall.size())
                        chk({tag, ":fall_done"}, ofall[j], od[di]);
                end
                di++;
            end else begin
                if (ei < oe.size()) begin
                    c = oe[ei];
                    if (fq[j].kind == 1) begin
                        chk({tag, ":err_cyc"}, c, ed[fq[j].bi]);
                    end else begin
                        chk({tag, ":gap_err_cyc"},
                            (c >= ed[fq[j].bi] + GAP) &&
                            (c <= ed[fq[j].bi] + GAP + 1), 1);
                    end
                    if (j < ofall.size())
                        chk({tag, ":fall_err"}, ofall[j], c);
                end
                ei++;
            end
        end
        clear_all();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ":wr_en"}, wr_en, 1'b0);
        chk({tag, ":wr_addr"}, wr_addr, 32'h0);
        chk({tag, ":wr_data"}, wr_data, 32'h0);
        chk({tag, ":cpu_rst"}, cpu_rst, 1'b0);
        chk({tag, ":done"}, done, 1'b0);
        chk({tag, ":err"}, err, 1'b0);
    endtask

    initial begin
        logic [31:0] r;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        fw.push_back(32'h12345678);
        fw.push_back(32'hDEADBEEF);
        add_frame(32'h100, 2, -1);
        run_stream(1);
        compare_all("basic");

        push_b(8'h11);
        push_b(8'h22);
        add_frame(32'h40, 3, -1);
        run_stream(1);
        compare_all("junk");

        add_frame(32'h102, 2, -1);
        run_stream(1);
        compare_all("misalign");

        add_frame(32'h80, 0, -1);
        run_stream(1);
        compare_all("n0");

        add_frame(32'h300, 2, 2);
        add_frame(32'h400, 2, -1);
        run_stream(1);
        compare_all("gap");

        add_frame(32'hFFFFFFFC, 2, -1);
        run_stream(1);
        compare_all("wrap");

        for (int f = 0; f < 8; f++) begin
            r = $urandom;
            add_frame(r & 32'hFFFFFFFC, int'($urandom_range(1, 4)), -1);
        end
        run_stream(1);
        compare_all("random");

        add_frame(32'h200, 2, -1);
        while (sq.size() > 11) begin
            void'(sq.pop_back());
            void'(gq.pop_back());
        end
        run_stream(0);
        rst = 1'b1;
        @(negedge clk);
        chk_idle_outputs("midreset");
        rst = 1'b0;
        #1;
        clear_all();
        repeat (GAP + 10) @(negedge clk);
        chk("midreset:no_wr", ow.size(), 0);
        chk("midreset:no_done", od.size(), 0);
        chk("midreset:no_err", oe.size(), 0);
        chk("midreset:no_rise", orise.size(), 0);
        clear_all();

        add_frame(32'h500, 2, -1);
        run_stream(1);
        compare_all("recover");

        $display("%0d/%0d checks passed", nchk - nfail, nchk);
        $finish;
    end

endmodule
